hs_to_stream_packetizer: RTL and testbench
==========================================

Name: hs_to_stream_packetizer

Overview:
Upstream-facing counterpart of the stream-to-handshake adapter. It accepts 64-bit words from an HLS accelerator ap_hs output port, buffers them in a small FIFO, and emits them as an AXI-Stream with tlast marking packet boundaries. Packet framing comes from a length field in each packet's header word. It sits between the accelerator's outgoing message port and the runtime interconnect.

Parameters:
DEPTH, 4, FIFO depth in words; power of two, >= 2.
LEN_LSB, 0, bit position of the 8-bit payload-length field inside the header word.
ACC_ID, 0, 8-bit accelerator id driven on out_tid (used only with the optional feature).

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
in_hs  in  64  word from the accelerator
in_hs_ap_vld  in  1  word valid
in_hs_ap_ack  out  1  word accepted this cycle
out_tdata  out  64  stream data
out_tvalid  out  1  stream valid
out_tready  in  1  stream ready
out_tlast  out  1  last word of packet
out_tid  out  8  stream id (only with HS_PKT_TID_EN)

Behaviour:
- Clock is aclk; reset is aresetn, synchronous, active-low.
- Reset values: out_tvalid=0, FIFO empty, framing state HEADER, length counter 0. in_hs_ap_ack=0 while aresetn=0. out_tdata/out_tlast are don't-care while out_tvalid=0.
- Input handshake:
  - in_hs_ap_ack = !full, combinational from registered state only. It never depends on in_hs_ap_vld or out_tready.
  - A word transfers in any cycle where vld && ack.
- Output handshake:
  - Standard AXI-S; a word transfers when out_tvalid && out_tready.
  - out_tvalid = !empty; tdata/tlast come from the FIFO head and stay stable while stalled.
- Latency: a word accepted in cycle N is presented on out_tvalid in cycle N+1 at the earliest. Sustained throughput is 1 word/cycle when out_tready=1.
- Full: simultaneous push and pop while full is impossible, because ack=0 when full. A pop while full frees a slot; ack rises the next cycle.
- Empty: a push while empty gives out_tvalid=1 next cycle. There is no fall-through.
- Simultaneous push and pop when neither full nor empty: occupancy unchanged; pointers wrap modulo DEPTH.
- FIFO entry is 65 bits: {tlast, data}. tlast is computed at input time.
- Framing FSM (advances only on an input transfer):
  - HEADER: len = in_hs[LEN_LSB+7:LEN_LSB].
    - len==0: store with tlast=1 and stay in HEADER.
    - otherwise: store with tlast=0, load cnt=len, go to PAYLOAD.
  - PAYLOAD: store the word with tlast=(cnt==1) and decrement cnt. When cnt==1 is consumed, go to HEADER.
  - Maximum packet is 256 words (header + 255).
- Reset mid-packet: FIFO contents are discarded and the FSM returns to HEADER. The next accepted word is treated as a header. Downstream may see a truncated packet with no tlast; this is accepted.
- Occupancy counter width is clog2(DEPTH)+1, and it never exceeds DEPTH.

Optional Feature:
HS_PKT_TID_EN
- Defined: the out_tid port exists and is driven constantly with ACC_ID[7:0]. It is valid whenever out_tvalid=1, and 0 during reset.
- Undefined: out_tid is absent from the port list. All other behaviour is identical.

Decomposition:
- Shared package: framing state enum (HEADER, PAYLOAD), LEN_W=8 constant, and a header length-field extract function parameterised by LEN_LSB.
- Sub-module: a generic synchronous FIFO, hs_pkt_fifo (WIDTH=65, DEPTH). Framing logic stays in the top.

Test Plan:
- Single header 0x00 with out_tready=1 -> one beat with tdata=0x00, tlast=1, out_tvalid exactly one cycle, one cycle after ack.
- Header len=3 then payload 0xA1,0xA2,0xA3, back-to-back with ready=1 -> 4 beats; tlast only on 0xA3; 4 consecutive valid cycles.
- out_tready=0, DEPTH=4, vld held high with 6 words -> ack high for 4 transfers, then 0. Raise ready -> words drain in order, and ack returns one cycle after the first pop.
- Random vld/ready toggling over 200 packets with random len 0..255 -> scoreboard data order matches; tlast count equals 200; no beat lost or duplicated.
- Assert reset after header len=5 plus 2 payload words -> out_tvalid=0 next cycle. A new header 0x01 plus payload afterwards gives tlast on the payload word.
- With HS_PKT_TID_EN and ACC_ID=0x2C -> out_tid=0x2C on every beat; without the macro, the build has no out_tid port.

Source files
------------

// File: rtl/hs_to_stream_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// hs_to_stream_packetizer_pkg : shared framing types and header helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hs_to_stream_packetizer_pkg;

  typedef enum logic [0:0] {
    ST_HEADER  = 1'b0,
    ST_PAYLOAD = 1'b1
  } frame_state_e;

  localparam int LEN_W = 8;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [63:0] word, input int lsb);
    return LEN_W'(word >> lsb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hs_to_stream_packetizer_fifo.sv
// ---------------------------------------------------------------------------
// hs_pkt_fifo : synchronous FIFO, registered head, no fall-through
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hs_pkt_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/hs_to_stream_packetizer.sv
// ---------------------------------------------------------------------------
// hs_to_stream_packetizer : ap_hs words -> AXI-Stream with length-framed tlast
// Optional out_tid port via macro HS_PKT_TID_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hs_to_stream_packetizer
  import hs_to_stream_packetizer_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter int          LEN_LSB = 0,
  parameter logic [7:0]  ACC_ID  = 8'h00
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] in_hs,
  input  logic        in_hs_ap_vld,
  output logic        in_hs_ap_ack,
  output logic [63:0] out_tdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast
`ifdef HS_PKT_TID_EN
  ,
  output logic [7:0]  out_tid
`endif
);

  frame_state_e     state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] hdr_len_w;
  logic             tlast_in;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [64:0]      head;

  assign in_hs_ap_ack = aresetn && !fifo_full;
  assign push         = in_hs_ap_vld && in_hs_ap_ack;
  assign out_tvalid   = !fifo_empty;
  assign pop          = out_tvalid && out_tready;
  assign out_tdata    = head[63:0];
  assign out_tlast    = head[64];
  assign hdr_len_w    = hdr_len(in_hs, LEN_LSB);

`ifdef HS_PKT_TID_EN
  assign out_tid = aresetn ? ACC_ID : 8'h00;
`else
  logic unused_acc_id;
  assign unused_acc_id = ^ACC_ID;
`endif

  // tlast is resolved on the way in so the output side is a plain FIFO read.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tlast_in = 1'b0;
    case (state_q)
      ST_HEADER: begin
        tlast_in = (hdr_len_w == '0);
        if (push && hdr_len_w != '0) begin
          cnt_d   = hdr_len_w;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        tlast_in = (cnt_q == LEN_W'(1));
        if (push) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) state_d = ST_HEADER;
        end
      end
      default: state_d = ST_HEADER;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_HEADER;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  hs_pkt_fifo #(
    .WIDTH (65),
    .DEPTH (DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .push_data ({tlast_in, in_hs}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

`default_nettype wire

// File: tb/tb_hs_to_stream_packetizer.sv
// ---------------------------------------------------------------------------
// tb_hs_to_stream_packetizer : scoreboard bench for hs_to_stream_packetizer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hs_to_stream_packetizer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] in_hs = '0;
  logic        in_hs_ap_vld = 1'b0;
  logic        in_hs_ap_ack;
  logic [63:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic        out_tlast;
`ifdef HS_PKT_TID_EN
  logic [7:0]  out_tid;
`endif

  hs_to_stream_packetizer #(
    .DEPTH   (4),
    .LEN_LSB (0),
    .ACC_ID  (8'h2C)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .in_hs        (in_hs),
    .in_hs_ap_vld (in_hs_ap_vld),
    .in_hs_ap_ack (in_hs_ap_ack),
    .out_tdata    (out_tdata),
    .out_tvalid   (out_tvalid),
    .out_tready   (out_tready),
    .out_tlast    (out_tlast)
`ifdef HS_PKT_TID_EN
    ,
    .out_tid      (out_tid)
`endif
  );

  always #5 aclk = ~aclk;

  int          tests = 0;
  int          fails = 0;
  int          beats = 0;
  int          tlasts = 0;
  logic [64:0] sb[$];
  int          m_rem = 0;
  logic        m_tl;
  logic [64:0] m_exp;

  // Reference framing model and scoreboard, sampled mid-cycle.
  always @(negedge aclk) begin
    if (!aresetn) begin
      sb.delete();
      m_rem = 0;
    end else begin
      if (in_hs_ap_vld && in_hs_ap_ack) begin
        if (m_rem == 0) begin
          m_rem = int'(in_hs[7:0]);
          m_tl  = (m_rem == 0);
        end else begin
          m_tl  = (m_rem == 1);
          m_rem = m_rem - 1;
        end
        sb.push_back({m_tl, in_hs});
      end
      if (out_tvalid && out_tready) begin
        beats = beats + 1;
        if (out_tlast) tlasts = tlasts + 1;
        tests = tests + 1;
        if (sb.size() == 0) begin
          fails = fails + 1;
          $display("FAIL sb_underflow: got beat %h tlast %b, required no beat", out_tdata, out_tlast);
        end else begin
          m_exp = sb.pop_front();
          if ({out_tlast, out_tdata} !== m_exp)
          begin
            fails = fails + 1;
            $display("FAIL sb_beat: got %h tlast %b, required %h tlast %b",
                     out_tdata, out_tlast, m_exp[63:0], m_exp[64]);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; in_hs_ap_vld = 1'b0; out_tready = 1'b0;
    repeat (2) step();
    @(negedge aclk);
    tests++; if (in_hs_ap_ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b, required 0", in_hs_ap_ack); end
    tests++; if (out_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b, required 0", out_tvalid); end
    step();
    aresetn = 1'b1;
    @(negedge aclk);
    tests++; if (in_hs_ap_ack !== 1'b1) begin fails++; $display("FAIL post_reset_ack: got %b, required 1", in_hs_ap_ack); end
    tests++; if (out_tvalid !== 1'b0) begin fails++; $display("FAIL post_reset_tvalid: got %b, required 0", out_tvalid); end
    step();
  endtask

  task automatic test_single_header();
    out_tready = 1'b1; in_hs = 64'h0; in_hs_ap_vld = 1'b1;
    @(negedge aclk);
    tests++; if (in_hs_ap_ack !== 1'b1) begin fails++; $display("FAIL single_ack: got %b, required 1", in_hs_ap_ack); end
    step();
    in_hs_ap_vld = 1'b0;
    @(negedge aclk);
    tests++;
    if (out_tvalid !== 1'b1 || out_tlast !== 1'b1 || out_tdata !== 64'h0) begin
      fails++; $display("FAIL single_beat: got valid %b tlast %b data %h, required 1 1 0", out_tvalid, out_tlast, out_tdata);
    end
    step();
    @(negedge aclk);
    tests++; if (out_tvalid !== 1'b0) begin fails++; $display("FAIL single_one_cycle: got valid %b, required 0", out_tvalid); end
    step();
  endtask

  task automatic test_len3();
    logic [63:0] w [4];
    logic [7:0]  vbits;
    logic [7:0]  lbits;
    w[0] = 64'h03; w[1] = 64'hA1; w[2] = 64'hA2; w[3] = 64'hA3;
    vbits = '0; lbits = '0;
    out_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin in_hs = w[c]; in_hs_ap_vld = 1'b1; end
      else in_hs_ap_vld = 1'b0;
      @(negedge aclk);
      vbits[c] = out_tvalid;
      lbits[c] = out_tvalid && out_tlast;
      step();
    end
    tests++; if (vbits !== 8'b0001_1110) begin fails++; $display("FAIL len3_valid: got %b, required 00011110", vbits); end
    tests++; if (lbits !== 8'b0001_0000) begin fails++; $display("FAIL len3_tlast: got %b, required 00010000", lbits); end
  endtask

  task automatic test_full();
    logic [63:0] w [6];
    logic [6:0]  ackbits;
    int          idx;
    for (int i = 0; i < 6; i++) w[i] = 64'h100 + 64'(i);
    idx = 0; ackbits = '0;
    out_tready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      in_hs_ap_vld = (idx < 6);
      if (idx < 6) in_hs = w[idx];
      @(negedge aclk);
      ackbits[c] = in_hs_ap_ack;
      if (in_hs_ap_vld && in_hs_ap_ack) idx++;
      step();
    end
    tests++; if (ackbits !== 7'b000_1111) begin fails++; $display("FAIL full_ack_pattern: got %b, required 0001111", ackbits); end
    tests++; if (idx !== 4) begin fails++; $display("FAIL full_accepted: got %0d, required 4", idx); end
    out_tready = 1'b1;
    in_hs = w[idx]; in_hs_ap_vld = 1'b1;
    @(negedge aclk);
    tests++; if (in_hs_ap_ack !== 1'b0) begin fails++; $display("FAIL full_ack_hold: got %b, required 0", in_hs_ap_ack); end
    step();
    for (int c = 0; c < 30; c++) begin
      in_hs_ap_vld = (idx < 6);
      if (idx < 6) in_hs = w[idx];
      @(negedge aclk);
      if (c == 0) begin
        tests++; if (in_hs_ap_ack !== 1'b1) begin fails++; $display("FAIL full_ack_return: got %b, required 1", in_hs_ap_ack); end
      end
      if (in_hs_ap_vld && in_hs_ap_ack) idx++;
      step();
    end
    in_hs_ap_vld = 1'b0;
    tests++; if (idx !== 6) begin fails++; $display("FAIL full_all_accepted: got %0d, required 6", idx); end
    tests++; if (out_tvalid !== 1'b0 || sb.size() != 0) begin
      fails++; $display("FAIL full_drained: got valid %b pending %0d, required 0 0", out_tvalid, sb.size());
    end
  endtask

  task automatic test_reset_midpacket();
    logic [63:0] w [3];
    logic [63:0] d [2];
    logic        l [2];
    int          n;
    w[0] = 64'h05; w[1] = 64'hC1; w[2] = 64'hC2;
    out_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_hs = w[i]; in_hs_ap_vld = 1'b1;
      @(negedge aclk);
      step();
    end
    in_hs_ap_vld = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    step();
    @(negedge aclk);
    tests++; if (out_tvalid !== 1'b0) begin fails++; $display("FAIL midreset_tvalid: got %b, required 0", out_tvalid); end
    step();
    aresetn = 1'b1;
    step();
    out_tready = 1'b1;
    n = 0; d[0] = '0; d[1] = '0; l[0] = 1'b0; l[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_hs_ap_vld = (c < 2);
      in_hs = (c == 0) ? 64'h01 : 64'hB0;
      @(negedge aclk);
      if (out_tvalid && n < 2) begin d[n] = out_tdata; l[n] = out_tlast; n++; end
      step();
    end
    in_hs_ap_vld = 1'b0;
    tests++; if (n !== 2) begin fails++; $display("FAIL midreset_beats: got %0d, required 2", n); end
    tests++; if (l[0] !== 1'b0 || l[1] !== 1'b1 || d[1] !== 64'hB0) begin
      fails++; $display("FAIL midreset_tlast: got tlast %b%b data1 %h, required 01 b0", l[0], l[1], d[1]);
    end
  endtask

  task automatic test_random();
    logic [63:0] words[$];
    int          b0, t0, idx, cyc, len;
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(0, 255);
      words.push_back({$urandom, $urandom_range(0, 16777215), 8'(len)});
      for (int k = 0; k < len; k++) words.push_back({$urandom, $urandom});
    end
    b0 = beats; t0 = tlasts; idx = 0; cyc = 0;
    while ((idx < words.size() || out_tvalid) && cyc < 80000) begin
      in_hs_ap_vld = (idx < words.size()) && ($urandom_range(0, 9) < 8);
      if (idx < words.size()) in_hs = words[idx];
      out_tready = ($urandom_range(0, 9) < 8);
      @(negedge aclk);
      if (in_hs_ap_vld && in_hs_ap_ack) idx++;
      step();
      cyc++;
    end
    in_hs_ap_vld = 1'b0; out_tready = 1'b1;
    tests++; if (cyc >= 80000) begin fails++; $display("FAIL random_timeout: got %0d cycles, required < 80000", cyc); end
    tests++; if (beats - b0 != words.size()) begin fails++; $display("FAIL random_beats: got %0d, required %0d", beats - b0, words.size()); end
    tests++; if (tlasts - t0 != 200) begin fails++; $display("FAIL random_tlasts: got %0d, required 200", tlasts - t0); end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL random_pending: got %0d, required 0", sb.size()); end
  endtask

`ifdef HS_PKT_TID_EN
  task automatic test_tid();
    int n;
    n = 0;
    out_tready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_hs_ap_vld = (c < 3);
      in_hs = (c == 0) ? 64'h02 : 64'hD0 + 64'(c);
      @(negedge aclk);
      if (out_tvalid) begin
        n++;
        tests++; if (out_tid !== 8'h2C) begin fails++; $display("FAIL tid_value: got %h, required 2c", out_tid); end
      end
      step();
    end
    in_hs_ap_vld = 1'b0;
    tests++; if (n !== 3) begin fails++; $display("FAIL tid_beats: got %0d, required 3", n); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_header();
    test_len3();
    test_full();
    test_reset_midpacket();
    test_random();
`ifdef HS_PKT_TID_EN
    test_tid();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
